// File: rtl/bg_scroll_addr_gen.sv
// Background scroll address generator: per-frame slew-limited camera scroll plus a
// two-stage beam-to-address pipeline. Define BG_SCROLL_WRAP_EN for horizontal wrap.
module bg_scroll_addr_gen #(
    parameter int IMG_W          = 3182,
    parameter int IMG_H          = 480,
    parameter int SCREEN_W       = 640,
    parameter int ADDR_W         = 23,
    parameter int SCROLL_W       = 16,
    parameter int MAX_STEP       = 8,
    parameter int PARALLAX_SHIFT = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_start,
    input  logic                snap_req,
    input  logic [SCROLL_W-1:0] target_x,
    input  logic                pix_valid,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    output logic [ADDR_W-1:0]   addr,
    output logic                addr_valid,
    output logic                out_of_range,
    output logic [SCROLL_W-1:0] scroll_x
);

`ifdef BG_SCROLL_WRAP_EN
    localparam int MAX_SCROLL = IMG_W - 1;
`else
    localparam int MAX_SCROLL = IMG_W - SCREEN_W;
`endif

    // One extra bit so slew sums never wrap around.
    localparam logic [SCROLL_W:0] maxScrollX = (SCROLL_W + 1)'(MAX_SCROLL);
    localparam logic [SCROLL_W:0] stepX      = (SCROLL_W + 1)'(MAX_STEP);
    localparam logic [SCROLL_W:0] imgWScroll = (SCROLL_W + 1)'(IMG_W);
    localparam logic [ADDR_W-1:0] imgWAddr   = ADDR_W'(IMG_W);
    localparam logic [10:0]       imgHRow    = 11'(IMG_H);

    typedef enum logic [0:0] {
        SNAP,
        TRACK
    } state_t;

    state_t              stateReg, stateNext;
    logic [SCROLL_W-1:0] scrollReg, scrollNext;

    logic [SCROLL_W:0] shifted;
    logic [SCROLL_W:0] desired;
    logic [SCROLL_W:0] scrollExt;
    logic [SCROLL_W:0] upLimit;
    logic [SCROLL_W:0] downSum;
    logic [SCROLL_W:0] slewed;

    // Target conditioning and slew limiting.
    always_comb begin
        shifted = {1'b0, target_x >> PARALLAX_SHIFT};
`ifdef BG_SCROLL_WRAP_EN
        desired = (shifted >= imgWScroll) ? (shifted - imgWScroll) : shifted;
`else
        desired = shifted;
`endif
        if (desired > maxScrollX) begin
            desired = maxScrollX;
        end

        scrollExt = {1'b0, scrollReg};
        upLimit   = scrollExt + stepX;
        downSum   = desired + stepX;
        if (desired > upLimit) begin
            slewed = upLimit;
        end else if (downSum < scrollExt) begin
            slewed = scrollExt - stepX;
        end else begin
            slewed = desired;
        end
    end

    // A snap request arriving with frame_start is honoured by that same frame_start.
    always_comb begin
        stateNext  = stateReg;
        scrollNext = scrollReg;
        if (frame_start) begin
            if (stateReg == SNAP || snap_req || MAX_STEP == 0) begin
                scrollNext = desired[SCROLL_W-1:0];
            end else begin
                scrollNext = slewed[SCROLL_W-1:0];
            end
            stateNext = TRACK;
        end else if (snap_req) begin
            stateNext = SNAP;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateReg  <= SNAP;
            scrollReg <= '0;
        end else begin
            stateReg  <= stateNext;
            scrollReg <= scrollNext;
        end
    end

    assign scroll_x = scrollReg;

    logic [ADDR_W-1:0] colSum;
    logic [ADDR_W-1:0] colNext;
    logic [ADDR_W-1:0] rowBaseReg;
    logic [ADDR_W-1:0] colReg;
    logic              oorReg;
    logic              validReg;

    always_comb begin
        colSum = ADDR_W'(DrawX) + ADDR_W'(scrollReg);
`ifdef BG_SCROLL_WRAP_EN
        colNext = (colSum >= imgWAddr) ? (colSum - imgWAddr) : colSum;
`else
        colNext = colSum;
`endif
    end

    // Stage 1: row base multiply and column offset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rowBaseReg <= '0;
            colReg     <= '0;
            oorReg     <= 1'b0;
            validReg   <= 1'b0;
        end else begin
            rowBaseReg <= ADDR_W'(DrawY) * imgWAddr;
            colReg     <= colNext;
            oorReg     <= ({1'b0, DrawY} >= imgHRow);
            validReg   <= pix_valid;
        end
    end

    // Stage 2: final address; rows below the image read address 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr         <= '0;
            out_of_range <= 1'b0;
            addr_valid   <= 1'b0;
        end else begin
            addr         <= oorReg ? '0 : (rowBaseReg + colReg);
            out_of_range <= oorReg;
            addr_valid   <= validReg;
        end
    end

endmodule
